// File: rtl/vram_console_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vram_console_pkg
// Description : Shared types and constants for the VRAM text console.
// Revision    : 1.0
// ============================================================================
package vram_console_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PUT     = 3'd1,
        ST_SCR_RD  = 3'd2,
        ST_SCR_WR  = 3'd3,
        ST_CLR_ROW = 3'd4,
        ST_CLR_ALL = 3'd5
    } state_t;

    localparam logic [7:0] c_cr       = 8'h0D;
    localparam logic [7:0] c_lf       = 8'h0A;
    localparam logic [7:0] c_bs       = 8'h08;
    localparam logic [7:0] c_ff       = 8'h0C;
    localparam logic [7:0] c_print_lo = 8'h20;
    localparam logic [7:0] c_print_hi = 8'h7E;

    localparam int c_cols          = 64;
    localparam int c_words_per_row = c_cols / 2;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= c_print_lo) && (b <= c_print_hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vram_console.sv
`default_nettype none
// ============================================================================
// Module      : vram_console
// Description : Byte-stream text writer for the 64x40 character VRAM with
//               cursor tracking, auto-wrap and hardware scroll/clear.
// Revision    : 1.0
// ============================================================================
module vram_console
    import vram_console_pkg::*;
#(
    parameter logic [15:0] BASE  = 16'hF200,
    parameter int          COLS  = c_cols,
    parameter int          ROWS  = 40,
    parameter logic [7:0]  BLANK = 8'h20
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_en,
    output logic        mem_wr,
    output logic        mem_wide,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_din,
    input  logic [15:0] mem_dout,
    input  logic        mem_ack,
    output logic        busy,
    output logic [5:0]  cur_col,
    output logic [5:0]  cur_row
);

    localparam int          WORDS_PER_ROW    = COLS / 2;
    localparam logic [5:0]  c_last_col       = 6'(COLS - 1);
    localparam logic [5:0]  c_last_row       = 6'(ROWS - 1);
    localparam logic [10:0] c_scroll_last    = 11'(WORDS_PER_ROW * (ROWS - 1) - 1);
    localparam logic [10:0] c_clr_last       = 11'(WORDS_PER_ROW * ROWS - 1);
    localparam logic [10:0] c_row_last_w     = 11'(WORDS_PER_ROW - 1);
    localparam logic [15:0] c_row_bytes      = 16'(COLS);
    localparam logic [15:0] c_last_row_base  = 16'(BASE + 16'(COLS * (ROWS - 1)));
    localparam logic [15:0] c_blank_word     = {BLANK, BLANK};

    state_t      r_state, w_state;
    logic [5:0]  r_col, w_col;
    logic [5:0]  r_row, w_row;
    logic [10:0] r_wcnt, w_wcnt;
    logic        r_en, w_en;
    logic        r_wr, w_wr;
    logic        r_wide, w_wide;
    logic [15:0] r_addr, w_addr;
    logic [15:0] r_din, w_din;      // doubles as the scroll read-holding register
    logic        w_adv;

    logic [15:0] w_cell_addr;
    logic [10:0] w_wcnt_inc;
    logic [15:0] w_word_off;
    logic [15:0] w_next_word_off;

    assign w_cell_addr     = BASE + 16'(r_row) * c_row_bytes + 16'(r_col);
    assign w_wcnt_inc      = r_wcnt + 11'd1;
    assign w_word_off      = {4'd0, r_wcnt, 1'b0};
    assign w_next_word_off = {4'd0, w_wcnt_inc, 1'b0};

    always_comb begin
        w_state = r_state;
        w_col   = r_col;
        w_row   = r_row;
        w_wcnt  = r_wcnt;
        w_en    = r_en;
        w_wr    = r_wr;
        w_wide  = r_wide;
        w_addr  = r_addr;
        w_din   = r_din;
        w_adv   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    if (is_printable(in_data)) begin
                        w_state = ST_PUT;
                        w_en    = 1'b1;
                        w_wr    = 1'b1;
                        w_wide  = 1'b0;
                        w_addr  = w_cell_addr;
                        w_din   = {8'h00, in_data};
                    end else begin
                        case (in_data)
                            c_cr: w_col = 6'd0;
                            c_lf: w_adv = 1'b1;
                            c_bs: if (r_col != 6'd0) w_col = r_col - 6'd1;
                            c_ff: begin
                                w_state = ST_CLR_ALL;
                                w_wcnt  = 11'd0;
                                w_en    = 1'b1;
                                w_wr    = 1'b1;
                                w_wide  = 1'b1;
                                w_addr  = BASE;
                                w_din   = c_blank_word;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            ST_PUT: begin
                if (mem_ack) begin
                    if (r_col == c_last_col) begin
                        w_col = 6'd0;
                        w_adv = 1'b1;
                    end else begin
                        w_col   = r_col + 6'd1;
                        w_state = ST_IDLE;
                        w_en    = 1'b0;
                    end
                end
            end
            ST_SCR_RD: begin
                if (mem_ack) begin
                    w_state = ST_SCR_WR;
                    w_wr    = 1'b1;
                    w_addr  = BASE + w_word_off;
                    w_din   = mem_dout;
                end
            end
            ST_SCR_WR: begin
                if (mem_ack) begin
                    if (r_wcnt == c_scroll_last) begin
                        w_state = ST_CLR_ROW;
                        w_wcnt  = 11'd0;
                        w_addr  = c_last_row_base;
                        w_din   = c_blank_word;
                    end else begin
                        w_state = ST_SCR_RD;
                        w_wcnt  = w_wcnt_inc;
                        w_wr    = 1'b0;
                        w_addr  = BASE + c_row_bytes + w_next_word_off;
                    end
                end
            end
            ST_CLR_ROW: begin
                if (mem_ack) begin
                    if (r_wcnt == c_row_last_w) begin
                        w_state = ST_IDLE;
                        w_en    = 1'b0;
                    end else begin
                        w_wcnt = w_wcnt_inc;
                        w_addr = r_addr + 16'd2;
                    end
                end
            end
            ST_CLR_ALL: begin
                if (mem_ack) begin
                    if (r_wcnt == c_clr_last) begin
                        w_state = ST_IDLE;
                        w_en    = 1'b0;
                        w_col   = 6'd0;
                        w_row   = 6'd0;
                    end else begin
                        w_wcnt = w_wcnt_inc;
                        w_addr = r_addr + 16'd2;
                    end
                end
            end
            default: begin
                w_state = ST_IDLE;
                w_en    = 1'b0;
            end
        endcase

        // Row advance from LF or from wrapping past the last column
        if (w_adv) begin
            if (r_row < c_last_row) begin
                w_row   = r_row + 6'd1;
                w_state = ST_IDLE;
                w_en    = 1'b0;
            end else begin
                w_state = ST_SCR_RD;
                w_wcnt  = 11'd0;
                w_en    = 1'b1;
                w_wr    = 1'b0;
                w_wide  = 1'b1;
                w_addr  = BASE + c_row_bytes;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_col   <= 6'd0;
            r_row   <= 6'd0;
            r_wcnt  <= 11'd0;
            r_en    <= 1'b0;
            r_wr    <= 1'b0;
            r_wide  <= 1'b0;
            r_addr  <= 16'd0;
            r_din   <= 16'd0;
        end else begin
            r_state <= w_state;
            r_col   <= w_col;
            r_row   <= w_row;
            r_wcnt  <= w_wcnt;
            r_en    <= w_en;
            r_wr    <= w_wr;
            r_wide  <= w_wide;
            r_addr  <= w_addr;
            r_din   <= w_din;
        end
    end

    assign in_ready = (r_state == ST_IDLE);
    assign busy     = (r_state != ST_IDLE);
    assign mem_en   = r_en;
    assign mem_wr   = r_wr;
    assign mem_wide = r_wide;
    assign mem_addr = r_addr;
    assign mem_din  = r_din;
    assign cur_col  = r_col;
    assign cur_row  = r_row;

endmodule
`default_nettype wire

// File: tb/tb_vram_console.sv
`default_nettype none
// ============================================================================
// Module      : tb_vram_console
// Description : Self-checking bench for vram_console with a byte-addressed
//               VRAM model and programmable ack latency.
// Revision    : 1.0
// ============================================================================
module tb_vram_console;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready, mem_en, mem_wr, mem_wide, mem_ack, busy;
    logic [15:0] mem_addr, mem_din, mem_dout;
    logic [5:0]  cur_col, cur_row;

    vram_console dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .mem_en   (mem_en),
        .mem_wr   (mem_wr),
        .mem_wide (mem_wide),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_dout (mem_dout),
        .mem_ack  (mem_ack),
        .busy     (busy),
        .cur_col  (cur_col),
        .cur_row  (cur_row)
    );

    always #5 clk = ~clk;

    // ---------------- memory model ----------------
    logic [7:0]  vram [0:65535];
    int          ack_delay = 0;
    int          wait_cnt  = 0;
    int          n_wr = 0, n_rd = 0, n_wide_wr = 0, n_stab_err = 0;
    longint      cyc = 0;
    logic        pend = 1'b0;
    logic        s_wr, s_wide;
    logic [15:0] s_addr, s_din;

    assign mem_ack  = mem_en && (wait_cnt >= ack_delay);
    assign mem_dout = {vram[mem_addr + 16'd1], vram[mem_addr]};

    always @(posedge clk) begin
        cyc++;
        if (pend && (mem_en !== 1'b1 || mem_wr !== s_wr || mem_wide !== s_wide ||
                     mem_addr !== s_addr || mem_din !== s_din))
            n_stab_err++;
        pend   = mem_en && !mem_ack && reset_n;
        s_wr   = mem_wr;
        s_wide = mem_wide;
        s_addr = mem_addr;
        s_din  = mem_din;
        if (mem_en && mem_ack) begin
            wait_cnt <= 0;
            if (mem_wr) begin
                n_wr++;
                vram[mem_addr] <= mem_din[7:0];
                if (mem_wide) begin
                    n_wide_wr++;
                    vram[mem_addr + 16'd1] <= mem_din[15:8];
                end
            end else begin
                n_rd++;
            end
        end else if (mem_en) begin
            wait_cnt <= wait_cnt + 1;
        end else begin
            wait_cnt <= 0;
        end
    end

    // ---------------- checking helpers ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic feed(input logic [7:0] b, output longint t);
        int k = 0;
        @(negedge clk);
        while (!in_ready && k < 10000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 10000) begin
            n_checks++;
            n_errors++;
            $display("FAIL feed_timeout: in_ready still low for byte %0h", b);
        end
        in_valid = 1'b1;
        in_data  = b;
        t        = cyc;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_idle(output int nb);
        nb = 0;
        forever begin
            @(negedge clk);
            if (!busy) break;
            nb++;
            if (nb > 20000) begin
                n_checks++;
                n_errors++;
                $display("FAIL idle_timeout: busy still high after %0d cycles", nb);
                break;
            end
        end
    endtask

    task automatic send(input logic [7:0] b, output int nb);
        longint t;
        feed(b, t);
        wait_idle(nb);
    endtask

    typedef struct {
        logic [7:0] b;
        logic [5:0] col;
        logic [5:0] row;
        int         writes;
        int         busy_cyc;
    } vec_t;

    vec_t vt [12];

    initial begin
        longint t0, t1;
        int     nb, w0, r0, ww0, bad;

        for (int i = 0; i < 65536; i++) vram[i] = 8'h00;

        vt[0]  = '{8'h0D, 6'd0, 6'd0, 0, 0};   // CR
        vt[1]  = '{8'h08, 6'd0, 6'd0, 0, 0};   // BS at col 0
        vt[2]  = '{8'h07, 6'd0, 6'd0, 0, 0};   // ignored
        vt[3]  = '{8'h78, 6'd1, 6'd0, 1, 1};   // 'x' at F200
        vt[4]  = '{8'h08, 6'd0, 6'd0, 0, 0};   // BS
        vt[5]  = '{8'h0A, 6'd0, 6'd1, 0, 0};   // LF
        vt[6]  = '{8'h7A, 6'd1, 6'd1, 1, 1};   // 'z' at F240
        vt[7]  = '{8'h0D, 6'd0, 6'd1, 0, 0};   // CR
        vt[8]  = '{8'h7F, 6'd0, 6'd1, 0, 0};   // DEL ignored
        vt[9]  = '{8'h1F, 6'd0, 6'd1, 0, 0};   // ignored
        vt[10] = '{8'h7E, 6'd1, 6'd1, 1, 1};   // '~' upper bound at F240
        vt[11] = '{8'h20, 6'd2, 6'd1, 1, 1};   // space lower bound at F241

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_wr", mem_wr, 0);
        check("rst_mem_wide", mem_wide, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_din", mem_din, 0);
        check("rst_cursor", {cur_row, cur_col}, 0);
        reset_n = 1'b1;

        // "HI" back to back with zero-wait memory
        w0 = n_wr;
        feed(8'h48, t0);
        feed(8'h49, t1);
        wait_idle(nb);
        check("hi_gap", 32'(t1 - t0), 2);
        check("hi_busy", nb, 1);
        check("hi_byte0", vram[16'hF200], 8'h48);
        check("hi_byte1", vram[16'hF201], 8'h49);
        check("hi_writes", n_wr - w0, 2);
        check("hi_cursor", {cur_row, cur_col}, {6'd0, 6'd2});

        // Single-byte vectors
        for (int i = 0; i < 12; i++) begin
            w0 = n_wr;
            send(vt[i].b, nb);
            check($sformatf("vec%0d_col", i), cur_col, vt[i].col);
            check($sformatf("vec%0d_row", i), cur_row, vt[i].row);
            check($sformatf("vec%0d_writes", i), n_wr - w0, vt[i].writes);
            check($sformatf("vec%0d_busy", i), nb, vt[i].busy_cyc);
        end
        check("vec_x_mem", vram[16'hF200], 8'h78);
        check("vec_tilde_mem", vram[16'hF240], 8'h7E);
        check("vec_space_mem", vram[16'hF241], 8'h20);

        // Form feed with 3-cycle ack latency
        ack_delay = 3;
        ww0 = n_wide_wr;
        w0  = n_wr;
        send(8'h0C, nb);
        check("ff_wide_writes", n_wide_wr - ww0, 1280);
        check("ff_all_writes", n_wr - w0, 1280);
        check("ff_busy", nb, 5120);
        check("ff_cursor", {cur_row, cur_col}, 0);
        check("ff_stable", n_stab_err, 0);
        bad = 0;
        for (int a = 16'hF200; a <= 16'hFBFF; a++) if (vram[a] !== 8'h20) bad++;
        check("ff_blank_cells", bad, 0);
        check("ff_below", vram[16'hF1FF], 8'h00);
        check("ff_above", vram[16'hFC00], 8'h00);
        ack_delay = 0;

        // Wrap from column 63 to next row
        for (int i = 0; i < 64; i++) send(8'h41, nb);
        send(8'h42, nb);
        check("wrap_b_mem", vram[16'hF240], 8'h42);
        check("wrap_a_last", vram[16'hF23F], 8'h41);
        check("wrap_cursor", {cur_row, cur_col}, {6'd1, 6'd1});

        // Scroll: preload row 1, walk cursor to row 39, then LF
        for (int i = 0; i < 32; i++) begin
            vram[16'hF240 + 16'(2 * i)]     <= 8'h42;
            vram[16'hF240 + 16'(2 * i + 1)] <= 8'h41;
        end
        send(8'h0D, nb);
        for (int i = 0; i < 38; i++) send(8'h0A, nb);
        check("pre_scroll_cursor", {cur_row, cur_col}, {6'd39, 6'd0});
        w0 = n_wr;
        r0 = n_rd;
        send(8'h0A, nb);
        check("scr_busy", nb, 2528);
        check("scr_writes", n_wr - w0, 1280);
        check("scr_reads", n_rd - r0, 1248);
        check("scr_cursor", {cur_row, cur_col}, {6'd39, 6'd0});
        bad = 0;
        for (int i = 0; i < 32; i++)
            if ({vram[16'hF200 + 16'(2 * i + 1)], vram[16'hF200 + 16'(2 * i)]} !== 16'h4142) bad++;
        check("scr_row0_copy", bad, 0);
        bad = 0;
        for (int a = 16'hFBC0; a <= 16'hFBFF; a++) if (vram[a] !== 8'h20) bad++;
        check("scr_last_row_blank", bad, 0);
        check("scr_stable", n_stab_err, 0);

        // Character on the last cell: write, then scroll
        for (int i = 0; i < 63; i++) send(8'h43, nb);
        check("last_cell_cursor", {cur_row, cur_col}, {6'd39, 6'd63});
        send(8'h44, nb);
        check("last_cell_busy", nb, 2529);
        check("last_cell_d_moved", vram[16'hFBBF], 8'h44);
        check("last_cell_c_moved", vram[16'hFBBE], 8'h43);
        check("last_cell_row_blank0", vram[16'hFBC0], 8'h20);
        check("last_cell_row_blank63", vram[16'hFBFF], 8'h20);
        check("last_cell_cursor_after", {cur_row, cur_col}, {6'd39, 6'd0});

        // Reset in the middle of a scroll
        feed(8'h0A, t0);
        repeat (100) @(posedge clk);
        @(negedge clk);
        check("mid_scroll_busy", busy, 1);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        w0 = n_wr;
        check("mid_rst_mem_en", mem_en, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_cursor", {cur_row, cur_col}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (50) @(posedge clk);
        @(negedge clk);
        check("mid_rst_no_writes", n_wr - w0, 0);
        check("mid_rst_in_ready", in_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
